// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the MIPS pipeline. Captures the decoded control
// word, operands and register specifiers of the instruction in ID. Detects
// load-use hazards (stalls the front end and inserts a bubble), applies
// branch/jump flushes from EX (remembering a flush that arrives during a hold),
// freezes on downstream holds, and counts load-use bubbles with saturation.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   id_valid, id_ctrl       valid bit and control word of the ID instruction
//   id_rs/rt/rd             register specifiers
//   id_rdata1/2, id_imm     register-file read data, sign-extended immediate
//   id_pc4                  PC+4 of the ID instruction
//   flush                   kill the ID instruction (taken branch/jump in EX)
//   hold                    downstream stall, freeze this stage
//   ex_*                    registered copies of the accepted ID values
//   pc_write, ifid_write    front-end enables (combinational)
//   stall_cnt               saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CW = 13,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          id_valid,
    input  logic [CW-1:0] id_ctrl,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic          flush,
    input  logic          hold,
    output logic          ex_valid,
    output logic [CW-1:0] ex_ctrl,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic          pc_write,
    output logic          ifid_write,
    output logic [15:0]   stall_cnt
);

    localparam int MEMRD_BIT = 5;

    logic        flushPend_r;
    logic        flushEff_s;
    logic        rtMatch_s;
    logic        loadUse_s;
    logic [15:0] cntNext_s;

    // Load-use detection: a load in EX whose destination feeds the ID instruction.
    always_comb begin
        flushEff_s = flush | flushPend_r;
        rtMatch_s  = (ex_rt == id_rs) || (ex_rt == id_rt);
        if (ex_valid && ex_ctrl[MEMRD_BIT] && (ex_rt != 5'd0) && id_valid &&
            !flushEff_s && rtMatch_s) begin
            loadUse_s = 1'b1;
        end else begin
            loadUse_s = 1'b0;
        end
    end

    // Front-end enables; a flush does not stall because fetch replaces the killed slot.
    always_comb begin
        pc_write   = ~(hold | loadUse_s);
        ifid_write = ~(hold | loadUse_s);
    end

    // Saturating increment of the bubble counter.
    always_comb begin
        if (stall_cnt == 16'hFFFF) begin
            cntNext_s = stall_cnt;
        end else begin
            cntNext_s = stall_cnt + 16'd1;
        end
    end

    // Remember a flush that arrives while frozen so it is applied once the hold releases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flushPend_r <= 1'b0;
        end else if (hold) begin
            if (flush) begin
                flushPend_r <= 1'b1;
            end else begin
                flushPend_r <= flushPend_r;
            end
        end else begin
            flushPend_r <= 1'b0;
        end
    end

    // Valid bit, control word and bubble counter; bubbles always zero the control word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= {CW{1'b0}};
            stall_cnt <= 16'd0;
        end else if (hold) begin
            ex_valid  <= ex_valid;
            ex_ctrl   <= ex_ctrl;
            stall_cnt <= stall_cnt;
        end else if (flushEff_s) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= {CW{1'b0}};
            stall_cnt <= stall_cnt;
        end else if (loadUse_s) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= {CW{1'b0}};
            stall_cnt <= cntNext_s;
        end else begin
            ex_valid  <= id_valid;
            ex_ctrl   <= id_valid ? id_ctrl : {CW{1'b0}};
            stall_cnt <= stall_cnt;
        end
    end

    // Data and specifiers load whenever not held; their value under a bubble is ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_rs     <= 5'd0;
            ex_rt     <= 5'd0;
            ex_rd     <= 5'd0;
            ex_rdata1 <= {DW{1'b0}};
            ex_rdata2 <= {DW{1'b0}};
            ex_imm    <= {DW{1'b0}};
            ex_pc4    <= {DW{1'b0}};
        end else if (!hold) begin
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
        end else begin
            ex_rs     <= ex_rs;
            ex_rt     <= ex_rt;
            ex_rd     <= ex_rd;
            ex_rdata1 <= ex_rdata1;
            ex_rdata2 <= ex_rdata2;
            ex_imm    <= ex_imm;
            ex_pc4    <= ex_pc4;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    localparam int CW = 13;
    localparam int DW = 32;
    localparam logic [CW-1:0] LW  = 13'h0224;  // MemRd | RegWrite | ALUsrc
    localparam logic [CW-1:0] ADD = 13'h0302;  // RegWrite | REGdst | ALUop=2
    localparam logic [CW-1:0] SUB = 13'h0303;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [CW-1:0] id_ctrl = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic [DW-1:0] id_rdata1 = '0, id_rdata2 = '0, id_imm = '0, id_pc4 = '0;
    logic          flush = 1'b0, hold = 1'b0;
    logic          ex_valid;
    logic [CW-1:0] ex_ctrl;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic          pc_write, ifid_write;
    logic [15:0]   stall_cnt;

    int  nTests = 0;
    int  nFail  = 0;
    bit  checkEn = 1'b0;

    id_ex_stage #(.CW(CW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .pc_write(pc_write), .ifid_write(ifid_write), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: the instruction currently sitting in EX plus bookkeeping.
    bit            mValid, mPend;
    logic [CW-1:0] mCtrl;
    logic [4:0]    mRs, mRt, mRd;
    logic [DW-1:0] mR1, mR2, mImm, mPc;
    int unsigned   mCnt;

    function automatic bit mLu();
        return mValid && mCtrl[5] && (mRt != 5'd0) && id_valid && !(flush || mPend) &&
               ((mRt == id_rs) || (mRt == id_rt));
    endfunction

    always @(posedge clock or negedge reset_n) begin
        bit lu, fe;
        if (!reset_n) begin
            mValid = 0; mPend = 0; mCtrl = '0; mCnt = 0;
            mRs = '0; mRt = '0; mRd = '0; mR1 = '0; mR2 = '0; mImm = '0; mPc = '0;
        end else begin
            lu = mLu();
            fe = flush || mPend;
            if (hold) begin
                if (flush) mPend = 1;
            end else begin
                mPend = 0;
                mRs = id_rs; mRt = id_rt; mRd = id_rd;
                mR1 = id_rdata1; mR2 = id_rdata2; mImm = id_imm; mPc = id_pc4;
                if (fe) begin
                    mValid = 0; mCtrl = '0;
                end else if (lu) begin
                    mValid = 0; mCtrl = '0;
                    if (mCnt < 32'd65535) mCnt = mCnt + 1;
                end else begin
                    mValid = id_valid;
                    mCtrl  = id_valid ? id_ctrl : '0;
                end
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset_n && checkEn) begin
            check("m_ex_valid", ex_valid, mValid);
            check("m_ex_ctrl", ex_ctrl, mCtrl);
            check("m_stall_cnt", stall_cnt, mCnt);
            check("m_pc_write", pc_write, !(hold || mLu()));
            check("m_ifid_write", ifid_write, !(hold || mLu()));
            if (mValid) begin
                check("m_ex_rs", ex_rs, mRs);
                check("m_ex_rt", ex_rt, mRt);
                check("m_ex_rd", ex_rd, mRd);
                check("m_ex_rdata1", ex_rdata1, mR1);
                check("m_ex_rdata2", ex_rdata2, mR2);
                check("m_ex_imm", ex_imm, mImm);
                check("m_ex_pc4", ex_pc4, mPc);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setId(bit v, logic [CW-1:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
    endtask

    function automatic logic [4:0] pickReg(int unsigned k);
        case (k % 4)
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'd10;
        endcase
    endfunction

    initial begin
        // Reset state
        #12;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_data", ex_rdata1 | ex_rdata2 | ex_imm | ex_pc4, 0);
        check("rst_pc_write", pc_write, 1);
        hold = 1; #1;
        check("rst_pc_write_hold", pc_write, 0);
        hold = 0;
        @(negedge clock);
        reset_n = 1; checkEn = 1;

        // Load then dependent use
        tick(); setId(1, LW, 5'd9, 5'd8, 5'd0);
        tick(); setId(1, ADD, 5'd8, 5'd10, 5'd11);
        @(negedge clock);
        check("lu_pc_write", pc_write, 0);
        check("lu_ifid_write", ifid_write, 0);
        tick(); @(negedge clock);
        check("lu_bubble_valid", ex_valid, 0);
        check("lu_bubble_ctrl", ex_ctrl, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_pc_write_after", pc_write, 1);
        tick(); @(negedge clock);
        check("lu_add_rs", ex_rs, 8);
        check("lu_add_ctrl", ex_ctrl, ADD);

        // Load to $zero
        tick(); setId(1, LW, 5'd9, 5'd0, 5'd0);
        tick(); setId(1, ADD, 5'd0, 5'd0, 5'd11);
        @(negedge clock);
        check("zero_pc_write", pc_write, 1);
        tick(); @(negedge clock);
        check("zero_ctrl", ex_ctrl, ADD);
        check("zero_stall_cnt", stall_cnt, 1);

        // Flush collides with hazard
        tick(); setId(1, LW, 5'd9, 5'd8, 5'd0);
        tick(); setId(1, ADD, 5'd8, 5'd10, 5'd11); flush = 1;
        @(negedge clock);
        check("fl_pc_write", pc_write, 1);
        tick(); flush = 0;
        @(negedge clock);
        check("fl_valid", ex_valid, 0);
        check("fl_ctrl", ex_ctrl, 0);
        check("fl_stall_cnt", stall_cnt, 1);

        // Flush during hold
        tick(); setId(1, ADD, 5'd1, 5'd2, 5'd3);
        tick(); hold = 1; flush = 1; setId(1, SUB, 5'd4, 5'd5, 5'd6);
        tick(); flush = 0;
        @(negedge clock);
        check("fh_frozen_ctrl", ex_ctrl, ADD);
        check("fh_frozen_rs", ex_rs, 1);
        tick(); hold = 0;
        @(negedge clock);
        check("fh_frozen2_ctrl", ex_ctrl, ADD);
        tick(); @(negedge clock);
        check("fh_bubble_valid", ex_valid, 0);
        check("fh_bubble_ctrl", ex_ctrl, 0);
        tick(); @(negedge clock);
        check("fh_load_ctrl", ex_ctrl, SUB);
        check("fh_load_rs", ex_rs, 4);

        // Counter saturation
        tick();
        force dut.stall_cnt = 16'hFFFE;
        mCnt = 32'hFFFE;
        #1 release dut.stall_cnt;
        setId(1, LW, 5'd8, 5'd8, 5'd0);
        tick(); tick(); @(negedge clock);
        check("sat_first", stall_cnt, 16'hFFFF);
        tick(); tick(); @(negedge clock);
        check("sat_second", stall_cnt, 16'hFFFF);

        // Asynchronous reset mid-stream
        tick(); setId(1, 13'h1FFF, 5'd3, 5'd4, 5'd5);
        tick(); hold = 1; flush = 1;
        @(negedge clock);
        check("ar_full_ctrl", ex_ctrl, 13'h1FFF);
        tick(); flush = 0;
        #2 reset_n = 0;
        #1;
        check("ar_valid", ex_valid, 0);
        check("ar_ctrl", ex_ctrl, 0);
        check("ar_spec", {ex_rs, ex_rt, ex_rd}, 0);
        check("ar_data", ex_rdata1 | ex_rdata2 | ex_imm | ex_pc4, 0);
        check("ar_stall_cnt", stall_cnt, 0);
        check("ar_pc_write_hold", pc_write, 0);
        hold = 0; #1;
        check("ar_pc_write", pc_write, 1);
        setId(1, ADD, 5'd1, 5'd2, 5'd3);
        tick(); #2 reset_n = 1;
        tick(); @(negedge clock);
        check("ar_pend_cleared_valid", ex_valid, 1);
        check("ar_pend_cleared_ctrl", ex_ctrl, ADD);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            setId(($urandom % 8) != 0, $urandom, pickReg($urandom), pickReg($urandom), pickReg($urandom));
            flush = ($urandom % 10) == 0;
            hold  = ($urandom % 8) == 0;
        end
        tick(); hold = 0; flush = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the MIPS pipeline. It registers the decoded control word from the control unit together with the operands and register specifiers of the instruction in ID. It detects load-use hazards and, when one occurs, stalls the front end and inserts a bubble. It also applies branch/jump flushes from EX and downstream holds, and keeps a saturating stall counter for performance checks.

## Interface
- `CW` — default 13 — width of the control word.
- `DW` — default 32 — width of the datapath.
- `clock` in 1 — rising-edge clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `id_valid` in 1 — ID holds a real instruction.
- `id_ctrl` in CW — control-unit outputs, packed as:
  - [1:0] ALUop
  - [2] ALUsrc
  - [3] Branch
  - [4] J
  - [5] MemRd
  - [6] MemWr
  - [7] MemtoReg
  - [8] REGdst
  - [9] RegWrite
  - [10] bne
  - [11] isslt
  - [12] sijal
- `id_rs`, `id_rt`, `id_rd` in 5 each — register specifiers.
- `id_rdata1`, `id_rdata2` in DW each — register-file read data.
- `id_imm` in DW — sign-extended immediate.
- `id_pc4` in DW — PC+4 of the instruction in ID.
- `flush` in 1 — taken branch/jump resolved in EX; kill the instruction in ID.
- `hold` in 1 — downstream stall; freeze this stage.
- `ex_valid` out 1 — registered copy of the accepted valid bit.
- `ex_ctrl` out CW — registered control word.
- `ex_rs`, `ex_rt`, `ex_rd` out 5 each — registered specifiers.
- `ex_rdata1`, `ex_rdata2`, `ex_imm`, `ex_pc4` out DW each — registered data.
- `pc_write` out 1 — PC may advance (combinational).
- `ifid_write` out 1 — IF/ID register may load (combinational).
- `stall_cnt` out 16 — saturating count of load-use bubbles.

## Operation
- **Load-use hazard.** `lu = ex_valid & ex_ctrl[5] & (ex_rt != 0) & id_valid & ~flush_eff & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- **Pending flush.** `flush_eff = flush | flush_pend`. `flush_pend` is a 1-bit register:
  - set when `flush & hold`;
  - cleared on the first clock edge with `hold = 0`.
- **Per-edge action, in priority order:**
  1. `hold`: all `ex_*` registers keep their value, and `stall_cnt` keeps its value.
  2. `flush_eff`: bubble — `ex_valid <= 0`, `ex_ctrl <= 0`; data registers load (don't-care).
  3. `lu`: bubble, and `stall_cnt <= sat(stall_cnt + 1)`.
  4. Otherwise: load all `id_*` inputs; `ex_valid <= id_valid`; `ex_ctrl <= id_valid ? id_ctrl : 0`.
- A bubble always forces `ex_ctrl` to all-zero. This guarantees no RegWrite, MemWr, Branch or J leaks from a killed instruction.
- **Front-end enables:** `pc_write = ifid_write = ~(hold | lu)`.
  - A flush does not stall: the killed ID instruction is replaced by fetch.
- **Saturation:** `stall_cnt` stops at 16'hFFFF and never wraps.
- **Zero register:** `ex_rt == 0` never causes a hazard.
- **Simultaneous events:**
  - `lu` and `flush`: flush wins, and `stall_cnt` is not incremented.
  - `hold` and `lu`: hold wins; `lu` is re-evaluated after the hold releases.

## Timing
- **Reset:** on `reset_n` low, immediately and asynchronously:
  - all `ex_*` outputs go to 0;
  - `ex_valid` = 0, `stall_cnt` = 0, `flush_pend` = 0.
  - `pc_write` and `ifid_write` then evaluate to `~hold`.
- **Reset mid-operation:** an in-flight instruction is discarded, and no partial state survives.
- **Latency:** the stage is one register stage, so `id_*` values accepted at edge N appear on `ex_*` after edge N.
- **Load-use bubble:** lasts exactly one cycle. After the bubble `ex_ctrl[5]` = 0, so `lu` deasserts and the held ID instruction loads on the next edge.
- **Combinational paths:**
  - `lu` and the write enables are combinational from `ex_*` registers, `id_*` inputs, `flush`, `hold` and `flush_pend`.
  - There is no combinational path from `id_*` to `ex_*` outputs.

## Test plan
- **Load then dependent use:**
  - EX holds `lw` (MemRd = 1, `ex_rt` = 8); ID holds `add` with `id_rs` = 8.
  - → `pc_write` = `ifid_write` = 0 for one cycle.
  - → Next edge: `ex_valid` = 0, `ex_ctrl` = 0, `stall_cnt` = 1.
  - → Following edge: the `add` loads with `ex_rs` = 8.
- **Load to $zero:** `lw` with `ex_rt` = 0 and `id_rs` = 0 → no stall, `stall_cnt` unchanged.
- **Flush collides with hazard:**
  - `flush` = 1 in the same cycle as `lu` conditions.
  - → Bubble inserted; `pc_write` = 1; `stall_cnt` unchanged.
- **Flush during hold:**
  - `hold` = 1 with `flush` pulsed for one cycle, then `hold` = 0 for 3 cycles.
  - → `ex_*` frozen during the hold.
  - → First edge after release: bubble.
  - → Next edge: the ID instruction loads normally.
- **Counter saturation:**
  - Preload via 65535 hazards, or force `stall_cnt` = 16'hFFFE.
  - Two hazards → reads 16'hFFFF after both, with no wrap.
- **Asynchronous reset mid-stream:**
  - Pipe full with `ex_ctrl` = 13'h1FFF; drop `reset_n` between edges.
  - → All outputs are 0 before the next clock edge, and `flush_pend` is cleared.
